// File: rtl/fig_04b_block_074_register_file_pkg.sv
// Shared SuperFX register-file constants: word width and special register indices.
package fig_04b_block_074_register_file_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned NUM_REGS = 16;

    localparam logic [3:0] R_PC     = 4'd15;
    localparam logic [3:0] R_ROMPTR = 4'd14;

    typedef logic [WORD_W-1:0] word_t;

    // How the Z-bus lands in the addressed register on a committed edge.
    typedef enum logic [1:0] {
        ZW_NONE = 2'b00,
        ZW_FULL = 2'b01,
        ZW_LOW  = 2'b10
    } zwrite_kind_e;

    function automatic zwrite_kind_e zwrite_kind(input logic zwrite, input logic zlow_only,
                                                 input logic stall);
        if (!zwrite || stall)
            return ZW_NONE;
        return zlow_only ? ZW_LOW : ZW_FULL;
    endfunction

    function automatic word_t merge_zbus(input word_t cur, input word_t zbus,
                                         input zwrite_kind_e kind);
        case (kind)
            ZW_FULL: return zbus;
            ZW_LOW:  return {cur[WORD_W-1:8], zbus[7:0]};
            default: return cur;
        endcase
    endfunction

endpackage

// File: rtl/fig_04b_block_074_register_file.sv
// SuperFX R0..R15 register file with Z-bus write port and R15 program-counter increment.
// Optional R14 ROM-buffer fetch pulse is enabled by defining R14_ROM_TRIGGER_EN.
module fig_04b_block_074_register_file
    import fig_04b_block_074_register_file_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  zsel,
    input  logic [15:0] zbus,
    input  logic        zwrite,
    input  logic        zlow_only,
    input  logic        pc_inc,
    input  logic        stall,
    output logic [15:0] r00,
    output logic [15:0] r01,
    output logic [15:0] r02,
    output logic [15:0] r03,
    output logic [15:0] r04,
    output logic [15:0] r05,
    output logic [15:0] r06,
    output logic [15:0] r07,
    output logic [15:0] r08,
    output logic [15:0] r09,
    output logic [15:0] r10,
    output logic [15:0] r11,
    output logic [15:0] r12,
    output logic [15:0] r13,
    output logic [15:0] r14,
    output logic [15:0] r15,
    output logic        rom_fetch
);

    word_t        regs_q [NUM_REGS];
    word_t        regs_d [NUM_REGS];
    zwrite_kind_e wkind;
    logic         pc_step;

    assign wkind = zwrite_kind(zwrite, zlow_only, stall);

    // A Z-bus write to R15 (full or low byte) always wins over the increment.
    assign pc_step = pc_inc && !stall && !((wkind != ZW_NONE) && (zsel == R_PC));

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (pc_step) begin
            regs_d[R_PC] = regs_q[R_PC] + 16'd1;
        end
        if (wkind != ZW_NONE) begin
            regs_d[zsel] = merge_zbus(regs_q[zsel], zbus, wkind);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[R_PC] <= RESET_PC;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef R14_ROM_TRIGGER_EN
    logic rom_fetch_q;
    logic rom_fetch_d;

    assign rom_fetch_d = (wkind != ZW_NONE) && (zsel == R_ROMPTR);

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_fetch_q <= 1'b0;
        end else begin
            rom_fetch_q <= rom_fetch_d;
        end
    end

    assign rom_fetch = rom_fetch_q;
`else
    assign rom_fetch = 1'b0;
`endif

    assign r00 = regs_q[0];
    assign r01 = regs_q[1];
    assign r02 = regs_q[2];
    assign r03 = regs_q[3];
    assign r04 = regs_q[4];
    assign r05 = regs_q[5];
    assign r06 = regs_q[6];
    assign r07 = regs_q[7];
    assign r08 = regs_q[8];
    assign r09 = regs_q[9];
    assign r10 = regs_q[10];
    assign r11 = regs_q[11];
    assign r12 = regs_q[12];
    assign r13 = regs_q[13];
    assign r14 = regs_q[14];
    assign r15 = regs_q[15];

endmodule
